format_decoder: RTL and testbench

- Pipelined posit decoder: takes a WIDTH-bit posit word and produces the unpacked fields: sign, signed regime, exponent and left-aligned fraction, plus zero and NaR flags.
- Inverse of the posit format encoder. Sits on the input side of the arithmetic datapath, so the fields it produces are exactly what the encoder consumes.
- 3-stage pipeline with valid/ready handshake on both sides and full backpressure support.

---
 rtl/format_decoder_pkg.sv | 31 +++
 rtl/format_decoder_if.sv | 51 +++++
 rtl/format_decoder_leading_run_counter.sv | 30 +++
 rtl/two_comp.sv | 14 +
 rtl/format_decoder.sv | 182 ++++++++++++++++++
 tb/tb_format_decoder.sv | 237 +++++++++++++++++++++++
 6 files changed

// File: rtl/format_decoder_pkg.sv
// format_decoder_pkg
//   Shared posit definitions for the decoder slice: default word geometry,
//   the unpacked field record (posit_fields_t) and the special bit patterns.
//   Optional feature macro used by the slice: FORMAT_DECODER_SCALE_EN.
package format_decoder_pkg;

    localparam int POSIT_WIDTH = 8;
    localparam int POSIT_EN    = 1;

    // Signed regime width: covers -(width-1) .. (width-2).
    function automatic int posit_w_reg(input int width);
        return $clog2(width) + 1;
    endfunction

    localparam int POSIT_W_REG = posit_w_reg(POSIT_WIDTH);
    localparam int POSIT_W_EXP = (POSIT_EN > 0) ? POSIT_EN : 1;
    localparam int POSIT_W_MAN = POSIT_WIDTH;

    typedef struct packed {
        logic                          n_r;
        logic signed [POSIT_W_REG-1:0] regime;
        logic [POSIT_W_EXP-1:0]        exponent;
        logic [POSIT_W_MAN-1:0]        mantissa;
        logic                          is_zero;
        logic                          is_nar;
    } posit_fields_t;

    localparam logic [POSIT_WIDTH-1:0] POSIT_NAR_PATTERN  = {1'b1, {(POSIT_WIDTH-1){1'b0}}};
    localparam logic [POSIT_WIDTH-1:0] POSIT_ZERO_PATTERN = '0;

endpackage

// File: rtl/format_decoder_if.sv
// format_decoder_if
//   Handshake + field bundle around the posit decoder.
//   Input side : in_valid, in_ready, in_posit
//   Output side: out_valid, out_ready, n_r, regime, exponent, mantissa,
//                is_zero, is_nar (+ scale when FORMAT_DECODER_SCALE_EN)
//   slave  : decoder view
//   master : producer/consumer view
interface format_decoder_if
    import format_decoder_pkg::*;
#(
    parameter int WIDTH = POSIT_WIDTH,
    parameter int EN    = POSIT_EN
);
    localparam int W_REG = posit_w_reg(WIDTH);
    localparam int W_EXP = (EN > 0) ? EN : 1;
    localparam int W_MAN = WIDTH;

    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        in_posit;
    logic                    out_valid;
    logic                    out_ready;
    logic                    n_r;
    logic signed [W_REG-1:0] regime;
    logic [W_EXP-1:0]        exponent;
    logic [W_MAN-1:0]        mantissa;
    logic                    is_zero;
    logic                    is_nar;
`ifdef FORMAT_DECODER_SCALE_EN
    logic signed [W_REG+EN-1:0] scale;
`endif

    modport slave (
        input  in_valid, in_posit, out_ready,
        output in_ready, out_valid, n_r, regime, exponent, mantissa,
               is_zero, is_nar
`ifdef FORMAT_DECODER_SCALE_EN
        , output scale
`endif
    );

    modport master (
        output in_valid, in_posit, out_ready,
        input  in_ready, out_valid, n_r, regime, exponent, mantissa,
               is_zero, is_nar
`ifdef FORMAT_DECODER_SCALE_EN
        , input scale
`endif
    );

endinterface

// File: rtl/format_decoder_leading_run_counter.sv
// leading_run_counter
//   Combinational length of the run of bits equal to the MSB, scanning from
//   the MSB downward. Result is 1..W.
//   i_bits  : vector to scan
//   o_count : run length
module leading_run_counter #(
    parameter int W  = 7,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  i_bits,
    output logic [CW-1:0] o_count
);

    logic w_stop;

    always_comb begin
        o_count = '0;
        w_stop  = 1'b0;
        for (int unsigned i = 0; i < W; i++) begin
            if (!w_stop) begin
                if (i_bits[W-1-i] == i_bits[W-1]) begin
                    o_count = o_count + CW'(1);
                end else begin
                    w_stop = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/two_comp.sv
// two_comp
//   Combinational two's complement negation.
//   i_a   : operand
//   o_neg : -i_a modulo 2^W
module two_comp #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    output logic [W-1:0] o_neg
);

    assign o_neg = ~i_a + W'(1);

endmodule

// File: rtl/format_decoder.sv
// format_decoder
//   3-stage pipelined posit decoder with valid/ready on both sides.
//     stage 1: sign, zero/NaR flags, magnitude body (two's complement if negative)
//     stage 2: regime run length -> signed regime, remainder after the run
//     stage 3: exponent/mantissa split, specials forced to zero
//   Ports:
//     clk   : clock
//     rst_n : asynchronous active-low reset
//     bus   : format_decoder_if.slave (input word handshake, decoded fields)
//   Optional: FORMAT_DECODER_SCALE_EN adds bus.scale = regime*2^EN + exponent.
module format_decoder
    import format_decoder_pkg::*;
#(
    parameter int WIDTH = POSIT_WIDTH,
    parameter int EN    = POSIT_EN
) (
    input  logic             clk,
    input  logic             rst_n,
    format_decoder_if.slave  bus
);

    localparam int W_REG = posit_w_reg(WIDTH);
    localparam int W_EXP = (EN > 0) ? EN : 1;
    localparam int W_MAN = WIDTH;
    localparam int W_BOD = WIDTH - 1;

    localparam logic [WIDTH-1:0] L_NAR  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] L_ZERO = '0;

    // ---------------- handshake chain ----------------
    logic r1_v, r2_v, r3_v;
    logic w_adv1, w_adv2, w_adv3;

    assign w_adv3 = !r3_v || bus.out_ready;
    assign w_adv2 = !r2_v || w_adv3;
    assign w_adv1 = !r1_v || w_adv2;

    assign bus.in_ready  = w_adv1;
    assign bus.out_valid = r3_v;

    // ---------------- stage 1 ----------------
    logic             r1_sign, r1_zero, r1_nar;
    logic [W_BOD-1:0] r1_body;
    logic [W_BOD-1:0] w_neg;

    // Negating only the low WIDTH-1 bits gives the same bits as negating the
    // whole word, since carries only propagate upward.
    two_comp #(.W(W_BOD)) u_neg (
        .i_a   (bus.in_posit[W_BOD-1:0]),
        .o_neg (w_neg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_v    <= 1'b0;
            r1_sign <= 1'b0;
            r1_zero <= 1'b0;
            r1_nar  <= 1'b0;
            r1_body <= '0;
        end else if (w_adv1) begin
            r1_v <= bus.in_valid;
            if (bus.in_valid) begin
                r1_sign <= bus.in_posit[WIDTH-1];
                r1_zero <= (bus.in_posit == L_ZERO);
                r1_nar  <= (bus.in_posit == L_NAR);
                r1_body <= bus.in_posit[WIDTH-1] ? w_neg : bus.in_posit[W_BOD-1:0];
            end
        end
    end

    // ---------------- stage 2 ----------------
    logic                    r2_sign, r2_zero, r2_nar;
    logic signed [W_REG-1:0] r2_regime;
    logic [W_BOD-1:0]        r2_rem;

    logic [W_REG-1:0]        w_run;
    logic signed [W_REG-1:0] w_run_s;
    logic signed [W_REG-1:0] w_regime;
    logic [W_REG-1:0]        w_shamt;
    logic [W_BOD-1:0]        w_rem;

    leading_run_counter #(.W(W_BOD), .CW(W_REG)) u_run (
        .i_bits  (r1_body),
        .o_count (w_run)
    );

    assign w_run_s  = signed'(w_run);
    assign w_regime = r1_body[W_BOD-1] ? (w_run_s - W_REG'(1)) : -w_run_s;
    // Shift by run + terminator; a full-width run shifts everything out.
    assign w_shamt  = w_run + W_REG'(1);
    assign w_rem    = r1_body << w_shamt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_v      <= 1'b0;
            r2_sign   <= 1'b0;
            r2_zero   <= 1'b0;
            r2_nar    <= 1'b0;
            r2_regime <= '0;
            r2_rem    <= '0;
        end else if (w_adv2) begin
            r2_v <= r1_v;
            if (r1_v) begin
                r2_sign   <= r1_sign;
                r2_zero   <= r1_zero;
                r2_nar    <= r1_nar;
                r2_regime <= w_regime;
                r2_rem    <= w_rem;
            end
        end
    end

    // ---------------- stage 3 ----------------
    logic                    r3_nr, r3_zero, r3_nar;
    logic signed [W_REG-1:0] r3_regime;
    logic [W_EXP-1:0]        r3_exp;
    logic [W_MAN-1:0]        r3_man;

    logic [W_EXP-1:0]        w_exp;
    logic [W_MAN-1:0]        w_man;
    logic                    w_special;

    generate
        if (EN > 0) begin : g_exp
            assign w_exp = r2_rem[W_BOD-1 -: EN];
        end else begin : g_noexp
            assign w_exp = '0;
        end
    endgenerate

    // Remainder padded to W_MAN, then the exponent bits are shifted out.
    assign w_man     = {r2_rem, 1'b0} << EN;
    assign w_special = r2_zero || r2_nar;

`ifdef FORMAT_DECODER_SCALE_EN
    localparam int W_SC = W_REG + EN;
    logic signed [W_SC-1:0] r3_scale;
    logic signed [W_SC-1:0] w_scale;

    assign w_scale = (W_SC'(r2_regime) << EN) + W_SC'(w_exp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r3_scale <= '0;
        end else if (w_adv3 && r2_v) begin
            r3_scale <= w_special ? '0 : w_scale;
        end
    end

    assign bus.scale = r3_scale;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r3_v      <= 1'b0;
            r3_nr     <= 1'b0;
            r3_zero   <= 1'b0;
            r3_nar    <= 1'b0;
            r3_regime <= '0;
            r3_exp    <= '0;
            r3_man    <= '0;
        end else if (w_adv3) begin
            r3_v <= r2_v;
            if (r2_v) begin
                r3_zero   <= r2_zero;
                r3_nar    <= r2_nar;
                r3_nr     <= w_special ? 1'b0 : r2_sign;
                r3_regime <= w_special ? '0 : r2_regime;
                r3_exp    <= w_special ? '0 : w_exp;
                r3_man    <= w_special ? '0 : w_man;
            end
        end
    end

    assign bus.n_r      = r3_nr;
    assign bus.regime   = r3_regime;
    assign bus.exponent = r3_exp;
    assign bus.mantissa = r3_man;
    assign bus.is_zero  = r3_zero;
    assign bus.is_nar   = r3_nar;

endmodule

// File: tb/tb_format_decoder.sv
// tb_format_decoder
//   Table-driven vectors through a scoreboard queue plus hand-written
//   sequences for latency, backpressure and asynchronous reset.
//   Optional: FORMAT_DECODER_SCALE_EN also checks bus.scale.
module tb_format_decoder;
    import format_decoder_pkg::*;

    localparam int W_SC = POSIT_W_REG + POSIT_EN;

    typedef struct packed {
        posit_fields_t          f;
        logic signed [W_SC-1:0] scale;
    } rec_t;

    typedef struct {
        logic [POSIT_WIDTH-1:0] posit;
        rec_t                   e;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    format_decoder_if #(.WIDTH(POSIT_WIDTH), .EN(POSIT_EN)) bus ();

    format_decoder #(.WIDTH(POSIT_WIDTH), .EN(POSIT_EN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_out   = 0;
    int   n_wait  = 0;
    rec_t sb_q[$];
    vec_t vecs[$];

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    function automatic rec_t mk(input logic nr, input int rg, input int ex,
                                input int man, input logic z, input logic nar);
        rec_t r;
        r.f.n_r      = nr;
        r.f.regime   = POSIT_W_REG'(rg);
        r.f.exponent = POSIT_W_EXP'(ex);
        r.f.mantissa = POSIT_W_MAN'(man);
        r.f.is_zero  = z;
        r.f.is_nar   = nar;
        r.scale      = W_SC'(rg * (1 << POSIT_EN) + ex);
        return r;
    endfunction

    function automatic posit_fields_t got_fields();
        posit_fields_t g;
        g.n_r      = bus.n_r;
        g.regime   = bus.regime;
        g.exponent = bus.exponent;
        g.mantissa = bus.mantissa;
        g.is_zero  = bus.is_zero;
        g.is_nar   = bus.is_nar;
        return g;
    endfunction

    // Output monitor: a transfer happens at the next posedge.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_out", 64'(1), 64'(0));
            end else begin
                rec_t e;
                e = sb_q.pop_front();
                check($sformatf("word_%0d", n_out), 64'(got_fields()), 64'(e.f));
`ifdef FORMAT_DECODER_SCALE_EN
                check($sformatf("scale_%0d", n_out), 64'(bus.scale), 64'(e.scale));
`endif
                n_out++;
            end
        end
    end

    task automatic send(input logic [POSIT_WIDTH-1:0] p, input rec_t e);
        bit done;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_posit = p;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb_q.push_back(e);
                @(posedge clk);
                #1;
                done = 1'b1;
            end else begin
                n_wait++;
            end
        end
        if (!done) check("send_timeout", 64'(0), 64'(1));
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 30 && sb_q.size() != 0; i++) @(negedge clk);
        check(nm, 64'(sb_q.size()), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int out_base;
        int stale;

        vecs.push_back('{8'h40, mk(0,  0, 0, 8'h00, 0, 0)});
        vecs.push_back('{8'h5A, mk(0,  0, 1, 8'hA0, 0, 0)});
        vecs.push_back('{8'h7F, mk(0,  6, 0, 8'h00, 0, 0)});
        vecs.push_back('{8'h01, mk(0, -6, 0, 8'h00, 0, 0)});
        vecs.push_back('{8'hC0, mk(1,  0, 0, 8'h00, 0, 0)});
        vecs.push_back('{POSIT_ZERO_PATTERN, mk(0, 0, 0, 8'h00, 1, 0)});
        vecs.push_back('{POSIT_NAR_PATTERN,  mk(0, 0, 0, 8'h00, 0, 1)});
        vecs.push_back('{8'h20, mk(0, -1, 0, 8'h00, 0, 0)});
        vecs.push_back('{8'h6C, mk(0,  1, 1, 8'h80, 0, 0)});
        vecs.push_back('{8'hA6, mk(1,  0, 1, 8'hA0, 0, 0)});
        vecs.push_back('{8'h41, mk(0,  0, 0, 8'h10, 0, 0)});
        vecs.push_back('{8'hFF, mk(1, -6, 0, 8'h00, 0, 0)});
        vecs.push_back('{8'h81, mk(1,  6, 0, 8'h00, 0, 0)});
        vecs.push_back('{8'h3F, mk(0, -1, 1, 8'hF0, 0, 0)});
        vecs.push_back('{8'h02, mk(0, -5, 0, 8'h00, 0, 0)});
        vecs.push_back('{8'h7E, mk(0,  5, 0, 8'h00, 0, 0)});

        bus.in_valid  = 1'b0;
        bus.in_posit  = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_fields", 64'(got_fields()), 64'(0));
`ifdef FORMAT_DECODER_SCALE_EN
        check("rst_scale", 64'(bus.scale), 64'(0));
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'(1));

        // Latency: out_valid rises after the third edge from accept
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(vecs[0].posit, vecs[0].e);
        @(negedge clk);
        @(negedge clk);
        check("lat_not_yet", 64'(bus.out_valid), 64'(0));
        @(negedge clk);
        check("lat_valid", 64'(bus.out_valid), 64'(1));
        drain("lat_drain");

        // Table stream, back-to-back with out_ready=1
        @(posedge clk);
        #1;
        n_wait = 0;
        out_base = n_out;
        foreach (vecs[i]) send(vecs[i].posit, vecs[i].e);
        check("throughput_waits", 64'(n_wait), 64'(0));
        drain("table_drain");
        check("table_count", 64'(n_out - out_base), 64'(vecs.size()));

        // Backpressure: three words fill the pipe, fourth is held
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        out_base = n_out;
        send(vecs[0].posit, vecs[0].e);
        send(vecs[1].posit, vecs[1].e);
        send(vecs[2].posit, vecs[2].e);
        bus.in_valid = 1'b1;
        bus.in_posit = vecs[3].posit;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("bp_in_ready_%0d", c), 64'(bus.in_ready), 64'(0));
            check($sformatf("bp_out_valid_%0d", c), 64'(bus.out_valid), 64'(1));
            check($sformatf("bp_stable_%0d", c), 64'(got_fields()), 64'(sb_q[0].f));
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(vecs[3].posit, vecs[3].e);
        drain("bp_drain");
        check("bp_count", 64'(n_out - out_base), 64'(4));

        // Asynchronous reset with two words in flight, one already at the output
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        send(8'h6C, mk(0, 1, 1, 8'h80, 0, 0));
        send(8'h81, mk(1, 6, 0, 8'h00, 0, 0));
        @(posedge clk);
        #1;
        check("mid_pre_valid", 64'(bus.out_valid), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_out_valid", 64'(bus.out_valid), 64'(0));
        check("mid_fields", 64'(got_fields()), 64'(0));
`ifdef FORMAT_DECODER_SCALE_EN
        check("mid_scale", 64'(bus.scale), 64'(0));
`endif
        sb_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("post_in_ready", 64'(bus.in_ready), 64'(1));
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        check("post_no_stale", 64'(stale), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
